// File: rtl/mem_port_arbiter_if.sv
// Signal bundle around mem_port_arbiter: fetch port, load/store port and BRAM side.
// slave is the arbiter's view; master is the view of the core plus memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              ls_req_i;
  logic              ls_we_i;
  logic [BE_W-1:0]   ls_be_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [DATA_W-1:0] ls_wdata_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [DATA_W-1:0] ls_rdata_o;

  logic              mem_en_o;
  logic [BE_W-1:0]   mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency BRAM port between instruction fetch and load/store.
// LS wins contention until MAX_LS_BURST back-to-back wins, then IF gets one slot.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int MAX_LS_BURST = 4
) (
  input  logic              clk_sys_i,
  input  logic              rst_n_i,
  mem_port_arbiter_if.slave bus
);
  typedef struct packed {
    logic valid;
    logic is_ls;
    logic is_write;
  } owner_t;

  logic       if_gnt;
  logic       ls_gnt;
  logic       any_gnt;
  logic [3:0] burst_cnt;
  logic [3:0] burst_cnt_nxt;
  owner_t     pipe [MEM_LATENCY];
  owner_t     head;

  // NOTE: defaults first in every always_comb, so no path can leave an output unassigned (no latch).
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (rst_n_i) begin
      if (bus.ls_req_i && (!bus.if_req_i || burst_cnt < 4'(MAX_LS_BURST)))
        ls_gnt = 1'b1;
      else if (bus.if_req_i)
        if_gnt = 1'b1;
    end
  end

  assign any_gnt = if_gnt | ls_gnt;

  // Counts LS wins that made IF wait; any IF win or IF going idle restarts it.
  always_comb begin
    burst_cnt_nxt = burst_cnt;
    if (if_gnt || !bus.if_req_i)
      burst_cnt_nxt = '0;
    else if (ls_gnt && burst_cnt < 4'(MAX_LS_BURST))
      burst_cnt_nxt = burst_cnt + 4'd1;
  end

  assign bus.mem_en_o    = any_gnt;
  assign bus.mem_addr_o  = ls_gnt ? bus.ls_addr_i : (if_gnt ? bus.if_addr_i : '0);
  assign bus.mem_wdata_o = ls_gnt ? bus.ls_wdata_i : '0;
  assign bus.mem_we_o    = (ls_gnt && bus.ls_we_i) ? bus.ls_be_i : '0;

  // NOTE: sequential state uses <= so every stage samples pre-edge values and the shift is order-independent.
  // NOTE: the owner pipeline is control state, not storage, so every entry is reset to drop in-flight responses.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      burst_cnt <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) pipe[i] <= '0;
    end else begin
      burst_cnt <= burst_cnt_nxt;
      pipe[0]   <= '{valid: any_gnt, is_ls: ls_gnt, is_write: ls_gnt & bus.ls_we_i};
      for (int i = MEM_LATENCY - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    end
  end

  // The last stage lines up with the BRAM read data for that access.
  assign head = pipe[MEM_LATENCY-1];

  assign bus.if_gnt_o    = if_gnt;
  assign bus.ls_gnt_o    = ls_gnt;
  assign bus.if_rvalid_o = head.valid & ~head.is_ls;
  assign bus.ls_rvalid_o = head.valid &  head.is_ls;
  assign bus.if_rdata_o  = (head.valid && !head.is_ls) ? bus.mem_rdata_i : '0;
  assign bus.ls_rdata_o  = (head.valid && head.is_ls && !head.is_write) ? bus.mem_rdata_i : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives two arbiters (MEM_LATENCY 1 and 3) with identical stimulus and checks them
// against a transaction-level model plus directed scenario checks.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 4;

  typedef struct packed {
    logic        if_gnt;
    logic        ls_gnt;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        if_rvalid;
    logic        ls_rvalid;
    logic [31:0] if_rdata;
    logic [31:0] ls_rdata;
  } obs_t;

  typedef struct {
    int          due;
    bit          is_ls;
    bit          is_wr;
    logic [31:0] addr;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [3:0]  ls_be = '0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1), .MAX_LS_BURST(MAXB)) u_l1 (
    .clk_sys_i(clk), .rst_n_i(rst_n), .bus(bus_a)
  );
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3), .MAX_LS_BURST(MAXB)) u_l3 (
    .clk_sys_i(clk), .rst_n_i(rst_n), .bus(bus_b)
  );

  assign bus_a.if_req_i = if_req;   assign bus_b.if_req_i = if_req;
  assign bus_a.if_addr_i = if_addr; assign bus_b.if_addr_i = if_addr;
  assign bus_a.ls_req_i = ls_req;   assign bus_b.ls_req_i = ls_req;
  assign bus_a.ls_we_i = ls_we;     assign bus_b.ls_we_i = ls_we;
  assign bus_a.ls_be_i = ls_be;     assign bus_b.ls_be_i = ls_be;
  assign bus_a.ls_addr_i = ls_addr; assign bus_b.ls_addr_i = ls_addr;
  assign bus_a.ls_wdata_i = ls_wdata; assign bus_b.ls_wdata_i = ls_wdata;

  obs_t obs [2];
  assign obs[0] = {bus_a.if_gnt_o, bus_a.ls_gnt_o, bus_a.mem_en_o, bus_a.mem_we_o, bus_a.mem_addr_o,
                   bus_a.mem_wdata_o, bus_a.if_rvalid_o, bus_a.ls_rvalid_o, bus_a.if_rdata_o, bus_a.ls_rdata_o};
  assign obs[1] = {bus_b.if_gnt_o, bus_b.ls_gnt_o, bus_b.mem_en_o, bus_b.mem_we_o, bus_b.mem_addr_o,
                   bus_b.mem_wdata_o, bus_b.if_rvalid_o, bus_b.ls_rvalid_o, bus_b.if_rdata_o, bus_b.ls_rdata_o};

  // BRAM stand-in: returns addr + 0xA000 a fixed number of cycles after an access, noise otherwise.
  logic [32:0] mpipe [2][4] = '{default: '0};
  logic [31:0] junk = '0;
  always @(posedge clk) begin
    junk <= $urandom;
    for (int d = 0; d < 2; d++) begin
      mpipe[d][0] <= {obs[d].mem_en, obs[d].mem_addr};
      for (int k = 1; k < 4; k++) mpipe[d][k] <= mpipe[d][k-1];
    end
  end
  assign bus_a.mem_rdata_i = mpipe[0][0][32] ? mpipe[0][0][31:0] + 32'hA000 : junk;
  assign bus_b.mem_rdata_i = mpipe[1][2][32] ? mpipe[1][2][31:0] + 32'hA000 : ~junk;

  // Reference model: LS-waiting count, outstanding responses per instance, cycle number.
  int         cyc = 0;
  int         bcnt = 0;
  logic [1:0] last_gnt = '0;  // {ls, if}
  rsp_t       rq [2][$];

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [1:0] model_gnt();
    bit if_turn;
    if (!rst_n) return 2'b00;
    if_turn = if_req && (!ls_req || bcnt >= MAXB);
    if (if_turn) return 2'b01;
    if (ls_req)  return 2'b10;
    return 2'b00;
  endfunction

  task automatic drive(input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
                       input logic [3:0] be, input logic [31:0] la, input logic [31:0] wd);
    if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw; ls_be = be; ls_addr = la; ls_wdata = wd;
  endtask

  // Called at a falling edge: scores both instances, then advances the model over the rising edge.
  task automatic sb_cycle();
    logic [1:0] g;
    obs_t       e;
    rsp_t       r;
    if (!rst_n) begin
      bcnt = 0;
      rq[0].delete();
      rq[1].delete();
    end
    g = model_gnt();
    for (int d = 0; d < 2; d++) begin
      e = '0;
      e.if_gnt = g[0];
      e.ls_gnt = g[1];
      e.mem_en = g[0] | g[1];
      if (g[1]) begin
        e.mem_addr  = ls_addr;
        e.mem_wdata = ls_wdata;
        if (ls_we) e.mem_we = ls_be;
      end else if (g[0]) begin
        e.mem_addr = if_addr;
      end
      if (rq[d].size() != 0 && rq[d][0].due == cyc) begin
        r = rq[d].pop_front();
        if (r.is_ls) begin
          e.ls_rvalid = 1'b1;
          e.ls_rdata  = r.is_wr ? 32'h0 : r.addr + 32'hA000;
        end else begin
          e.if_rvalid = 1'b1;
          e.if_rdata  = r.addr + 32'hA000;
        end
      end
      total++;
      if (obs[d] !== e) begin
        bad++;
        $display("FAIL scoreboard lat%0d cyc %0d: got %h want %h", lat(d), cyc, obs[d], e);
      end
    end
    @(posedge clk);
    if (rst_n && g != 2'b00) begin
      for (int d = 0; d < 2; d++) begin
        r.due = cyc + lat(d);
        r.is_ls = g[1];
        r.is_wr = g[1] & ls_we;
        r.addr = g[1] ? ls_addr : if_addr;
        rq[d].push_back(r);
      end
    end
    if (rst_n) begin
      if (g[0] || !if_req) bcnt = 0;
      else if (g[1] && bcnt < MAXB) bcnt++;
    end
    last_gnt = rst_n ? g : 2'b00;
    cyc++;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    sb_cycle();
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  task automatic test_reset();
    drive(1, 32'h20, 1, 1, 4'hF, 32'h24, 32'h1234);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs[d] !== '0) begin
        bad++;
        $display("FAIL reset_outputs lat%0d: got %h want 0", lat(d), obs[d]);
      end
    end
    total++;
    if (u_l1.burst_cnt !== 4'd0 || u_l3.burst_cnt !== 4'd0) begin
      bad++;
      $display("FAIL reset_burst_cnt: got %0d/%0d want 0", u_l1.burst_cnt, u_l3.burst_cnt);
    end
    sb_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_if_only();
    drive(1, 32'h10, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if ({obs[0].if_gnt, obs[0].ls_gnt} !== 2'b10 || obs[0].mem_addr !== 32'h10) begin
      bad++;
      $display("FAIL if_only_grant: got gnt=%b addr=%h want gnt=10 addr=00000010",
               {obs[0].if_gnt, obs[0].ls_gnt}, obs[0].mem_addr);
    end
    sb_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (obs[0].if_rvalid !== 1'b1 || obs[0].if_rdata !== 32'hA010) begin
      bad++;
      $display("FAIL if_only_resp: got v=%b d=%h want v=1 d=0000a010", obs[0].if_rvalid, obs[0].if_rdata);
    end
    sb_cycle();
    idle(4);
  endtask

  task automatic test_ls_write();
    drive(0, 0, 1, 1, 4'b0011, 32'h40, 32'hDEADBEEF);
    @(negedge clk);
    total++;
    if (obs[0].ls_gnt !== 1'b1 || obs[0].mem_we !== 4'b0011 || obs[0].mem_wdata !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL ls_write_mem: got gnt=%b we=%b wd=%h want gnt=1 we=0011 wd=deadbeef",
               obs[0].ls_gnt, obs[0].mem_we, obs[0].mem_wdata);
    end
    sb_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (obs[0].ls_rvalid !== 1'b1 || obs[0].ls_rdata !== 32'h0) begin
      bad++;
      $display("FAIL ls_write_resp: got v=%b d=%h want v=1 d=0", obs[0].ls_rvalid, obs[0].ls_rdata);
    end
    sb_cycle();
    idle(4);
  endtask

  task automatic test_contention();
    logic [1:0] seq [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    drive(1, 32'h100, 1, 0, 4'hF, 32'h200, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if ({obs[0].ls_gnt, obs[0].if_gnt} !== seq[k]) begin
        bad++;
        $display("FAIL contention_slot%0d: got {ls,if}=%b want %b", k, {obs[0].ls_gnt, obs[0].if_gnt}, seq[k]);
      end
      sb_cycle();
    end
    idle(4);
  endtask

  task automatic test_latency3();
    logic [65:0] want [6];  // {if_rvalid, ls_rvalid, if_rdata, ls_rdata}
    want = '{66'h0, 66'h0, 66'h0, {2'b10, 32'hA000, 32'h0}, {2'b01, 32'h0, 32'hA004}, {2'b10, 32'hA008, 32'h0}};
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: drive(1, 32'h0, 0, 0, 0, 0, 0);
        1: drive(0, 0, 1, 0, 4'hF, 32'h4, 0);
        2: drive(1, 32'h8, 0, 0, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0);
      endcase
      @(negedge clk);
      total++;
      if ({obs[1].if_rvalid, obs[1].ls_rvalid, obs[1].if_rdata, obs[1].ls_rdata} !== want[k]) begin
        bad++;
        $display("FAIL latency3_cycle%0d: got %h want %h", k,
                 {obs[1].if_rvalid, obs[1].ls_rvalid, obs[1].if_rdata, obs[1].ls_rdata}, want[k]);
      end
      sb_cycle();
    end
    idle(2);
  endtask

  task automatic test_reset_midflight();
    drive(1, 32'h300, 1, 0, 4'hF, 32'h400, 0);
    step();
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (u_l1.burst_cnt !== 4'd0 || u_l3.burst_cnt !== 4'd0) begin
      bad++;
      $display("FAIL midreset_burst_cnt: got %0d/%0d want 0", u_l1.burst_cnt, u_l3.burst_cnt);
    end
    sb_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (obs[1].if_rvalid !== 1'b0 || obs[1].ls_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL midreset_no_resp%0d: got if=%b ls=%b want 0 0", k, obs[1].if_rvalid, obs[1].ls_rvalid);
      end
      sb_cycle();
    end
    drive(1, 32'h500, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (obs[1].if_gnt !== 1'b1) begin
      bad++;
      $display("FAIL midreset_regrant: got %b want 1", obs[1].if_gnt);
    end
    sb_cycle();
    idle(2);
    @(negedge clk);
    total++;
    if (obs[1].if_rvalid !== 1'b1 || obs[1].if_rdata !== 32'hA500) begin
      bad++;
      $display("FAIL midreset_regrant_resp: got v=%b d=%h want v=1 d=0000a500", obs[1].if_rvalid, obs[1].if_rdata);
    end
    sb_cycle();
    idle(2);
  endtask

  task automatic test_idle();
    idle(4);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        total++;
        if ({obs[d].mem_en, obs[d].mem_we, obs[d].if_rvalid, obs[d].ls_rvalid} !== 7'b0) begin
          bad++;
          $display("FAIL idle_quiet lat%0d cyc%0d: got en=%b we=%b rv=%b%b want all 0", lat(d), k,
                   obs[d].mem_en, obs[d].mem_we, obs[d].if_rvalid, obs[d].ls_rvalid);
        end
      end
      sb_cycle();
    end
  endtask

  // Requesters keep request and payload until the model says they were granted.
  task automatic test_random(input int n);
    int p_if;
    int p_ls;
    for (int k = 0; k < n; k++) begin
      if (k % 100 == 0) begin
        p_if = $urandom_range(20, 100);
        p_ls = $urandom_range(20, 100);
      end
      if (!(if_req && !last_gnt[0])) begin
        if_req  = ($urandom_range(0, 99) < p_if);
        if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!(ls_req && !last_gnt[1])) begin
        ls_req   = ($urandom_range(0, 99) < p_ls);
        ls_we    = $urandom_range(0, 1);
        ls_be    = 4'($urandom);
        ls_addr  = $urandom;
        ls_wdata = $urandom;
      end
      rst_n = ($urandom_range(0, 149) != 0);
      step();
      rst_n = 1'b1;
    end
    idle(4);
  endtask

  initial begin
    test_reset();
    test_if_only();
    test_ls_write();
    test_contention();
    test_latency3();
    test_reset_midflight();
    test_idle();
    test_random(600);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port, fixed-latency memory between the core's instruction-fetch (IF) port and load/store (LS) port. Sits between the pipeline front-end/LSU and the on-chip BRAM inside `riscv_top`. Requests are granted in the same cycle. Responses come back in order, tagged to their owner. LS has priority, with a starvation guard for IF.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width (byte enables are `DATA_W/8` wide)
- `MEM_LATENCY`, 1, cycles from `mem_en_o` to valid `mem_rdata_i`; legal range 1..4
- `MAX_LS_BURST`, 4, consecutive LS grants allowed while IF waits; legal range 1..15

Ports:
- `clk_sys_i`  in  1  system clock, all state on the rising edge
- `rst_n_i`  in  1  asynchronous, active-low reset
- `if_req_i`  in  1  fetch request
- `if_addr_i`  in  ADDR_W  fetch address
- `if_gnt_o`  out  1  fetch accepted this cycle
- `if_rvalid_o`  out  1  fetch response valid
- `if_rdata_o`  out  DATA_W  fetch data
- `ls_req_i`  in  1  LS request
- `ls_we_i`  in  1  1 = write
- `ls_be_i`  in  DATA_W/8  byte enables
- `ls_addr_i`  in  ADDR_W  LS address
- `ls_wdata_i`  in  DATA_W  write data
- `ls_gnt_o`  out  1  LS accepted this cycle
- `ls_rvalid_o`  out  1  LS response valid (reads and writes)
- `ls_rdata_o`  out  DATA_W  LS read data
- `mem_en_o`  out  1  memory access strobe
- `mem_we_o`  out  DATA_W/8  per-byte write enable
- `mem_addr_o`  out  ADDR_W  memory address
- `mem_wdata_o`  out  DATA_W  memory write data
- `mem_rdata_i`  in  DATA_W  memory read data, valid MEM_LATENCY cycles after `mem_en_o`

## Operation
- **Grant logic** is combinational from the requests and `burst_cnt`. At most one grant per cycle. While `rst_n_i`=0, every grant and `mem_en_o` is 0.
  - Only one requester active: that requester is granted.
  - Both active and `burst_cnt < MAX_LS_BURST`: LS is granted.
  - Both active and `burst_cnt == MAX_LS_BURST`: IF is granted.
- **burst_cnt** is a 4-bit register, reset 0.
  - Increments when LS is granted while `if_req_i`=1.
  - Clears when IF is granted, or when `if_req_i`=0.
  - Saturates at `MAX_LS_BURST`.
- **Memory mux**
  - `mem_en_o` = any grant.
  - `mem_addr_o`/`mem_wdata_o` come from the winner; they are 0 when there is no grant.
  - `mem_we_o` = `ls_be_i` when LS is granted with `ls_we_i`=1, otherwise 0.
- **Owner pipeline**: a MEM_LATENCY-deep shift register of {valid, is_ls, is_write}, reset all 0. Each cycle it shifts in {grant, ls_gnt, ls_we_i & ls_gnt}.
- **Responses**, driven from the output stage:
  - `if_rvalid_o` = valid & !is_ls.
  - `ls_rvalid_o` = valid & is_ls.
  - `if_rdata_o` = `mem_rdata_i` when `if_rvalid_o`, else 0.
  - `ls_rdata_o` = `mem_rdata_i` for an LS read response; 0 for a write response or when idle.
- Requesters must hold request and payload until granted. Payload changes before grant are not checked.
- **Reset mid-operation** flushes the owner pipeline. In-flight responses are dropped, and no rvalid appears for pre-reset grants.

## Timing
- Grant latency is 0 cycles: request in cycle N, grant in cycle N when it wins.
- Response latency: grant in cycle N, rvalid in cycle N+MEM_LATENCY, exactly one cycle wide.
- Full throughput: one grant per cycle, with back-to-back grants to alternating owners allowed.
- Response order equals grant order. Responses never overlap, since there is one response per cycle.
- Output reset values: all grants 0, both rvalids 0, both rdata 0, `mem_en_o` 0, `mem_we_o` 0, `mem_addr_o` 0, `mem_wdata_o` 0, `burst_cnt` 0.

## Test plan
- **IF only.** `if_req_i`=1, addr 0x10, `mem_rdata_i` model returns addr+0xA000, MEM_LATENCY=1 → `if_gnt_o`=1 in the same cycle, `mem_addr_o`=0x10, next cycle `if_rvalid_o`=1 with `if_rdata_o`=0xA010.
- **LS write.** `ls_we_i`=1, `ls_be_i`=4'b0011, addr 0x40, wdata 0xDEADBEEF → `mem_we_o`=4'b0011, `mem_wdata_o`=0xDEADBEEF. One cycle later `ls_rvalid_o`=1 with `ls_rdata_o`=0.
- **Contention with starvation guard.** Both requesters held high for 10 cycles, MAX_LS_BURST=4 → grant sequence is LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
- **Latency 3.** MEM_LATENCY=3, alternating grants IF@0x0, LS read@0x4, IF@0x8 → rvalids arrive in cycles 3,4,5 to IF, LS, IF with the matching data.
- **Reset mid-flight.** MEM_LATENCY=3, pulse `rst_n_i` low for 1 cycle right after 2 grants → no rvalid follows and `burst_cnt`=0. The first post-reset request is granted normally.
- **Idle.** No requests → `mem_en_o`=0, `mem_we_o`=0, no rvalids for 20 cycles.
